pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage of the fetch pipeline.
//
// Holds the fetch address and steps it by INST_BYTES*FETCH_W each time the
// instruction memory grants a fetch and the PC stage is not stalled.
// Redirect priority is flush, then branch, then latched branch, then increment.
// A branch that arrives while the stage cannot advance is latched and applied
// on the next advance.
//
// Ports:
//   clk                      in   clock, rising edge
//   rst                      in   asynchronous active-low reset
//   stall    [STALL_W]       in   stall vector; only bit 0 freezes this stage
//   branch_flag_i            in   redirect request from decode
//   branch_target_address_i  in   redirect target
//   flush                    in   exception flush (highest priority)
//   new_pc                   in   exception handler entry
//   imem_gnt                 in   memory accepted the fetch at pc this cycle
//   pc                       out  current fetch address (registered)
//   ce                       out  fetch request / memory enable (registered)
//   redirect_pending_o       out  a branch target is latched, not yet applied
//   pc_misalign_o            out  pc is not INST_BYTES-aligned
module pc_fetch_unit #(
  parameter int unsigned              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]        RESET_VEC  = 32'hbfc00000,
  parameter int unsigned              INST_BYTES = 4,
  parameter int unsigned              FETCH_W    = 1,
  parameter int unsigned              STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               imem_gnt,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending_o,
  output logic               pc_misalign_o
);

  localparam logic [ADDR_W-1:0] Inc   = ADDR_W'(INST_BYTES * FETCH_W);
  localparam int unsigned       LsbW  = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;

  typedef enum logic {StHold, StRun} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_ce;
  logic                r_pend;
  logic [ADDR_W-1:0]   r_pend_tgt;
  logic                w_adv;

  // Only stall[0] matters to this stage; the rest belong to later stages.
  generate
    if (STALL_W > 1) begin : g_stall_unused
      logic w_unused_stall;
      assign w_unused_stall = ^stall[STALL_W-1:1];
    end
  endgenerate

  assign w_adv = (r_state == StRun) & imem_gnt & ~stall[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StHold;
      r_pc       <= RESET_VEC;
      r_ce       <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
    end else begin
      unique case (r_state)
        // One idle cycle after reset release; all redirects ignored here.
        StHold: begin
          r_state <= StRun;
          r_ce    <= 1'b1;
        end
        StRun: begin
          r_ce <= 1'b1;
          if (flush) begin
            r_pc   <= new_pc;
            r_pend <= 1'b0;
          end else if (branch_flag_i && w_adv) begin
            // A fresh branch supersedes any target already latched.
            r_pc   <= branch_target_address_i;
            r_pend <= 1'b0;
          end else if (branch_flag_i) begin
            r_pend     <= 1'b1;
            r_pend_tgt <= branch_target_address_i;
          end else if (r_pend && w_adv) begin
            r_pc   <= r_pend_tgt;
            r_pend <= 1'b0;
          end else if (w_adv) begin
            r_pc <= r_pc + Inc;  // wraps modulo 2^ADDR_W
          end
        end
        default: begin
          r_state <= StHold;
          r_ce    <= 1'b0;
        end
      endcase
    end
  end

  assign pc                 = r_pc;
  assign ce                 = r_ce;
  assign redirect_pending_o = r_pend;

  generate
    if (INST_BYTES > 1) begin : g_misalign
      assign pc_misalign_o = |r_pc[LsbW-1:0];
    end else begin : g_no_misalign
      assign pc_misalign_o = 1'b0;
    end
  endgenerate

endmodule
